// File: rtl/axil_ram_responder_if.sv
// AXI4-lite channel bundle between a CPU-side master and the RAM responder.
// Slave modport is the responder's view; master modport is the requester's.
interface axil_ram_responder_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport slave (
      input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      input  arvalid, araddr, arprot, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport master (
      output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
      output arvalid, araddr, arprot, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_ram_responder.sv
// AXI4-lite slave backed by a byte-strobed word RAM; independent write and read
// engines, one transaction outstanding each, optional read wait states.
module axil_ram_responder #(
   parameter int          MEM_WORDS  = 16384,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int          RD_LATENCY = 0,
   parameter string       G_HEXFILE  = ""
) (
   input  logic                  clk,
   input  logic                  resetn,
   axil_ram_responder_if.slave   s_axil
);

   localparam int         IDX_W  = $clog2(MEM_WORDS);
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic       {WR_IDLE, WR_RESP}          wr_state_t;
   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

   logic [31:0] mem [MEM_WORDS];

   function automatic logic [31:0] word_off(input logic [31:0] addr);
      return (addr - BASE_ADDR) >> 2;
   endfunction

   function automatic logic in_range(input logic [31:0] addr);
      return (addr >= BASE_ADDR) && (word_off(addr) < 32'(MEM_WORDS));
   endfunction

   // Readies stay low until the first edge after reset release.
   logic bus_en;

   wr_state_t   wr_state, wr_state_nxt;
   logic        aw_held, w_held;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;
   logic [1:0]  bresp_q;
   logic        awready_int, wready_int, aw_fire, w_fire;
   logic        wr_commit, wr_ok;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   logic [IDX_W-1:0] wr_idx;

   rd_state_t   rd_state, rd_state_nxt;
   logic [3:0]  rd_cnt;
   logic [31:0] ar_addr_q, rdata_q, rd_addr;
   logic [1:0]  rresp_q;
   logic        arready_int, ar_fire, rd_sample;
   logic [IDX_W-1:0] rd_idx;

   logic unused_prot;
   assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

   assign awready_int = bus_en && (wr_state == WR_IDLE) && !aw_held;
   assign wready_int  = bus_en && (wr_state == WR_IDLE) && !w_held;
   assign aw_fire     = s_axil.awvalid && awready_int;
   assign w_fire      = s_axil.wvalid && wready_int;

   // A held beat wins over the bus; otherwise the beat handshaking this edge is used.
   assign wr_addr   = aw_held ? aw_addr_q : s_axil.awaddr;
   assign wr_data   = w_held  ? w_data_q  : s_axil.wdata;
   assign wr_strb   = w_held  ? w_strb_q  : s_axil.wstrb;
   assign wr_commit = (aw_held || aw_fire) && (w_held || w_fire);
   assign wr_ok     = in_range(wr_addr);
   assign wr_idx    = IDX_W'(word_off(wr_addr));

   assign s_axil.awready = awready_int;
   assign s_axil.wready  = wready_int;
   assign s_axil.bvalid  = (wr_state == WR_RESP);
   assign s_axil.bresp   = bresp_q;

   always_comb begin
      wr_state_nxt = wr_state;
      case (wr_state)
         WR_IDLE: if (wr_commit)      wr_state_nxt = WR_RESP;
         WR_RESP: if (s_axil.bready)  wr_state_nxt = WR_IDLE;
         default:                     wr_state_nxt = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_en   <= 1'b0;
         wr_state <= WR_IDLE;
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         bresp_q  <= OKAY;
      end else begin
         bus_en   <= 1'b1;
         wr_state <= wr_state_nxt;
         aw_held  <= wr_commit ? 1'b0 : (aw_held || aw_fire);
         w_held   <= wr_commit ? 1'b0 : (w_held || w_fire);
         if (wr_commit) bresp_q <= wr_ok ? OKAY : SLVERR;
      end
   end

   always_ff @(posedge clk) begin
      if (aw_fire) aw_addr_q <= s_axil.awaddr;
      if (w_fire) begin
         w_data_q <= s_axil.wdata;
         w_strb_q <= s_axil.wstrb;
      end
      if (wr_commit && wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   assign arready_int = bus_en && (rd_state == RD_IDLE);
   assign ar_fire     = s_axil.arvalid && arready_int;
   // With no wait states the RAM is sampled on the AR handshake edge itself.
   assign rd_sample   = ((rd_state == RD_IDLE) && ar_fire && (RD_LATENCY == 0)) ||
                        ((rd_state == RD_WAIT) && (rd_cnt == 4'd0));
   assign rd_addr     = (rd_state == RD_IDLE) ? s_axil.araddr : ar_addr_q;
   assign rd_idx      = IDX_W'(word_off(rd_addr));

   assign s_axil.arready = arready_int;
   assign s_axil.rvalid  = (rd_state == RD_DATA);
   assign s_axil.rdata   = rdata_q;
   assign s_axil.rresp   = rresp_q;

   always_comb begin
      rd_state_nxt = rd_state;
      case (rd_state)
         RD_IDLE: if (ar_fire)        rd_state_nxt = (RD_LATENCY == 0) ? RD_DATA : RD_WAIT;
         RD_WAIT: if (rd_cnt == 4'd0) rd_state_nxt = RD_DATA;
         RD_DATA: if (s_axil.rready)  rd_state_nxt = RD_IDLE;
         default:                     rd_state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state <= RD_IDLE;
         rd_cnt   <= 4'd0;
         rdata_q  <= 32'd0;
         rresp_q  <= OKAY;
      end else begin
         rd_state <= rd_state_nxt;
         if (ar_fire)                    rd_cnt <= 4'(RD_LATENCY - 1);
         else if (rd_state == RD_WAIT)   rd_cnt <= rd_cnt - 4'd1;
         if (rd_sample) begin
            rdata_q <= in_range(rd_addr) ? mem[rd_idx] : 32'd0;
            rresp_q <= in_range(rd_addr) ? OKAY : SLVERR;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ar_fire) ar_addr_q <= s_axil.araddr;
   end

endmodule
